// File: rtl/modinv_keygen.sv
// -----------------------------------------------------------------------------
// modinv_keygen
//
// Computes the RSA private exponent d = e^-1 mod totient with the iterative
// extended Euclidean algorithm. Each Euclid step divides r0 by r1 with a
// bit-serial restoring divider (WIDTH cycles). One extra cycle then updates
// the remainder pair and the Bezout coefficient pair.
//
// Parameters
//   WIDTH    bit width of e, totient and d (4..64)
//
// Ports
//   clk      system clock, rising edge
//   rst      asynchronous active-low reset
//   start    request pulse, sampled only while idle
//   e        public exponent, latched on an accepted start
//   totient  modulus phi(n), latched on an accepted start
//   busy     high from the cycle after an accepted start until done rises
//   done     result valid (level), held until the next accepted start
//   err      valid with done: no inverse exists
//   d        private exponent in 1..totient-1, 0 when err=1
//   cycles   (only with MODINV_CYCLE_CNT_EN) saturating 16-bit count of
//            clock edges from the accepting edge up to done
//
// Optional feature macro: MODINV_CYCLE_CNT_EN
// -----------------------------------------------------------------------------
module modinv_keygen #(
    parameter int WIDTH = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] e,
    input  logic [WIDTH-1:0] totient,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] d
`ifdef MODINV_CYCLE_CNT_EN
    ,
    output logic [15:0]      cycles
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_DIV,
        S_UPDATE,
        S_FIX,
        S_FIN
    } state_t;

    localparam int CW = $clog2(WIDTH);

    state_t                  state_reg;
    logic [WIDTH-1:0]        e_reg;
    logic [WIDTH-1:0]        tot_reg;
    logic [WIDTH-1:0]        r0_reg;
    logic [WIDTH-1:0]        r1_reg;
    // Holds the dividend during DIV; the quotient bits shift in from the
    // right, so after WIDTH cycles it holds q.
    logic [WIDTH-1:0]        quo_reg;
    // Partial remainder needs one spare bit because it is shifted left
    // before the trial subtraction.
    logic [WIDTH:0]          rem_reg;
    logic signed [WIDTH:0]   t0_reg;
    logic signed [WIDTH:0]   t1_reg;
    logic [CW-1:0]           cnt_reg;
    logic                    busy_reg;
    logic                    done_reg;
    logic                    err_reg;
    logic [WIDTH-1:0]        d_reg;
`ifdef MODINV_CYCLE_CNT_EN
    logic [15:0]             cycles_reg;
`endif

    // ---------------- divider step ----------------
    logic [WIDTH:0]          rem_shift;
    logic [WIDTH:0]          rem_sub;
    logic                    quo_bit;

    assign rem_shift = {rem_reg[WIDTH-1:0], quo_reg[WIDTH-1]};
    assign rem_sub   = rem_shift - {1'b0, r1_reg};
    assign quo_bit   = (rem_shift >= {1'b0, r1_reg});

    // ---------------- coefficient update ----------------
    // q is unsigned, t1 is signed: both are widened to 2*WIDTH+2 bits so the
    // low WIDTH+1 bits of the unsigned product equal the two's-complement
    // product. Truncation is exact because every |t| stays below totient.
    logic [2*WIDTH+1:0]      q_ext;
    logic [2*WIDTH+1:0]      t1_ext;
    logic [2*WIDTH+1:0]      prod;
    logic signed [WIDTH:0]   t_new;

    assign q_ext  = {{(WIDTH+2){1'b0}}, quo_reg};
    assign t1_ext = {{(WIDTH+1){t1_reg[WIDTH]}}, t1_reg};
    assign prod   = q_ext * t1_ext;
    assign t_new  = t0_reg - $signed(prod[WIDTH:0]);

    // ---------------- final normalisation ----------------
    logic signed [WIDTH:0]   t0_plus;
    logic [WIDTH-1:0]        d_fix;

    assign t0_plus = t0_reg + $signed({1'b0, tot_reg});
    assign d_fix   = t0_reg[WIDTH] ? t0_plus[WIDTH-1:0] : t0_reg[WIDTH-1:0];

    // ---------------- control ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg  <= S_IDLE;
            e_reg      <= '0;
            tot_reg    <= '0;
            r0_reg     <= '0;
            r1_reg     <= '0;
            quo_reg    <= '0;
            rem_reg    <= '0;
            t0_reg     <= '0;
            t1_reg     <= '0;
            cnt_reg    <= '0;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
            err_reg    <= 1'b0;
            d_reg      <= '0;
`ifdef MODINV_CYCLE_CNT_EN
            cycles_reg <= '0;
`endif
        end else begin
`ifdef MODINV_CYCLE_CNT_EN
            // Counts every edge spent outside IDLE; the accept branch below
            // overrides this with a clear.
            if (state_reg != S_IDLE && cycles_reg != 16'hFFFF) begin
                cycles_reg <= cycles_reg + 16'd1;
            end
`endif
            case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        e_reg      <= e;
                        tot_reg    <= totient;
                        done_reg   <= 1'b0;
                        err_reg    <= 1'b0;
                        d_reg      <= '0;
                        busy_reg   <= 1'b1;
                        state_reg  <= S_INIT;
`ifdef MODINV_CYCLE_CNT_EN
                        cycles_reg <= '0;
`endif
                    end
                end

                S_INIT: begin
                    if (tot_reg < WIDTH'(2) || e_reg == '0) begin
                        err_reg   <= 1'b1;
                        d_reg     <= '0;
                        state_reg <= S_FIN;
                    end else begin
                        r0_reg    <= tot_reg;
                        r1_reg    <= e_reg;
                        t0_reg    <= '0;
                        t1_reg    <= (WIDTH+1)'(1);
                        quo_reg   <= tot_reg;
                        rem_reg   <= '0;
                        cnt_reg   <= '0;
                        state_reg <= S_DIV;
                    end
                end

                S_DIV: begin
                    rem_reg <= quo_bit ? rem_sub : rem_shift;
                    quo_reg <= {quo_reg[WIDTH-2:0], quo_bit};
                    cnt_reg <= cnt_reg + CW'(1);
                    if (cnt_reg == CW'(WIDTH-1)) begin
                        state_reg <= S_UPDATE;
                    end
                end

                S_UPDATE: begin
                    r0_reg  <= r1_reg;
                    r1_reg  <= rem_reg[WIDTH-1:0];
                    t0_reg  <= t1_reg;
                    t1_reg  <= t_new;
                    // Preload the next division with the new dividend (old r1).
                    quo_reg <= r1_reg;
                    rem_reg <= '0;
                    cnt_reg <= '0;
                    if (rem_reg[WIDTH-1:0] == '0) begin
                        state_reg <= S_FIX;
                    end else begin
                        state_reg <= S_DIV;
                    end
                end

                S_FIX: begin
                    // r0 now holds gcd(e, totient).
                    if (r0_reg != WIDTH'(1)) begin
                        err_reg <= 1'b1;
                        d_reg   <= '0;
                    end else begin
                        d_reg   <= d_fix;
                    end
                    state_reg <= S_FIN;
                end

                S_FIN: begin
                    done_reg  <= 1'b1;
                    busy_reg  <= 1'b0;
                    state_reg <= S_IDLE;
                end

                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

    assign busy = busy_reg;
    assign done = done_reg;
    assign err  = err_reg;
    assign d    = d_reg;
`ifdef MODINV_CYCLE_CNT_EN
    assign cycles = cycles_reg;
`endif

endmodule

// File: tb/tb_modinv_keygen.sv
// -----------------------------------------------------------------------------
// tb_modinv_keygen
//
// Self-checking bench for modinv_keygen (WIDTH=24). Directed vectors use
// known RSA examples; random vectors are checked against plain arithmetic:
// an inverse exists iff totient>=2, e!=0 and gcd(e,totient)==1, and then d is
// the unique value in 1..totient-1 with (e*d) mod totient == 1.
// Latency "lat" counts rising edges from the accepting edge (counted as 1)
// through the edge on which done rises.
// -----------------------------------------------------------------------------
module tb_modinv_keygen;

    localparam int W     = 24;
    localparam int BOUND = 1000;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] e;
    logic [W-1:0] totient;
    logic         busy;
    logic         done;
    logic         err;
    logic [W-1:0] d;
`ifdef MODINV_CYCLE_CNT_EN
    logic [15:0]  cycles;
`endif

    int total;
    int bad;

    modinv_keygen #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .e       (e),
        .totient (totient),
        .busy    (busy),
        .done    (done),
        .err     (err),
        .d       (d)
`ifdef MODINV_CYCLE_CNT_EN
        ,
        .cycles  (cycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference helpers ----------------
    function automatic longint unsigned gcd_ref(input longint unsigned a, input longint unsigned b);
        longint unsigned x;
        longint unsigned y;
        longint unsigned tmp;
        x = a;
        y = b;
        while (y != 0) begin
            tmp = x % y;
            x   = y;
            y   = tmp;
        end
        return x;
    endfunction

    function automatic bit invertible_ref(input longint unsigned ev, input longint unsigned tv);
        if (tv < 2 || ev == 0) return 1'b0;
        return gcd_ref(ev, tv) == 1;
    endfunction

    // Presents one request and waits (bounded) for done.
    task automatic run_op(input logic [W-1:0] ev, input logic [W-1:0] tv,
                          output int lat, output bit timed_out);
        @(negedge clk);
        e       = ev;
        totient = tv;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start     = 1'b0;
        lat       = 1;
        timed_out = 1'b1;
        for (int i = 0; i < BOUND; i++) begin
            @(posedge clk);
            #1;
            lat++;
            if (done === 1'b1) begin
                timed_out = 1'b0;
                break;
            end
        end
    endtask

    task automatic check_timeout(input string name, input bit timed_out, input int lat);
        total++;
        if (timed_out) begin
            $display("FAIL %s timeout: done not seen after %0d edges, required within %0d", name, lat, BOUND);
            bad++;
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst     = 1'b0;
        start   = 1'b0;
        e       = '0;
        totient = '0;
        #2;
        total++;
        if ({busy, done, err, d} !== {3'b000, {W{1'b0}}}) begin
            $display("FAIL reset_outputs busy=%b done=%b err=%b d=%0d, required all 0", busy, done, err, d);
            bad++;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({busy, done, err, d} !== {3'b000, {W{1'b0}}}) begin
            $display("FAIL idle_after_reset busy=%b done=%b err=%b d=%0d, required all 0", busy, done, err, d);
            bad++;
        end
        $display("reset: busy=%b done=%b err=%b d=%0d", busy, done, err, d);
    endtask

    task automatic test_basic();
        int lat;
        bit to;
        bit held_ok;
        run_op(24'd17, 24'd3120, lat, to);
        check_timeout("basic_17_3120", to, lat);
        total++;
        if (d !== 24'd2753 || err !== 1'b0) begin
            $display("FAIL basic_17_3120 d=%0d err=%b, required d=2753 err=0", d, err);
            bad++;
        end
        total++;
        if (busy !== 1'b0) begin
            $display("FAIL basic_busy_at_done busy=%b, required 0", busy);
            bad++;
        end
        held_ok = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            #1;
            if (d !== 24'd2753 || done !== 1'b1 || err !== 1'b0) held_ok = 1'b0;
        end
        total++;
        if (!held_ok) begin
            $display("FAIL basic_hold d=%0d done=%b err=%b, required d=2753 done=1 err=0 for 50 cycles", d, done, err);
            bad++;
        end
        $display("op e=17 totient=3120: d=%0d err=%b lat=%0d", d, err, lat);
    endtask

    task automatic test_busy_flag();
        bit busy_ok;
        @(negedge clk);
        e       = 24'd3;
        totient = 24'd20;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        total++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            $display("FAIL busy_after_accept busy=%b done=%b, required busy=1 done=0", busy, done);
            bad++;
        end
        busy_ok = 1'b0;
        for (int i = 0; i < BOUND; i++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) begin
                busy_ok = 1'b1;
                break;
            end
            if (busy !== 1'b1) break;
        end
        total++;
        if (!busy_ok || d !== 24'd7 || err !== 1'b0) begin
            $display("FAIL busy_until_done finished=%b d=%0d err=%b, required busy held then d=7 err=0", busy_ok, d, err);
            bad++;
        end
        $display("op e=3 totient=20 (busy watch): d=%0d err=%b", d, err);
    endtask

    task automatic test_small();
        int lat;
        bit to;
        run_op(24'd3, 24'd20, lat, to);
        check_timeout("small_3_20", to, lat);
        total++;
        if (d !== 24'd7 || err !== 1'b0) begin
            $display("FAIL small_3_20 d=%0d err=%b, required d=7 err=0", d, err);
            bad++;
        end
        $display("op e=3 totient=20: d=%0d err=%b lat=%0d", d, err, lat);
        run_op(24'd4, 24'd20, lat, to);
        check_timeout("small_4_20", to, lat);
        total++;
        if (d !== 24'd0 || err !== 1'b1) begin
            $display("FAIL small_4_20 d=%0d err=%b, required d=0 err=1", d, err);
            bad++;
        end
        $display("op e=4 totient=20: d=%0d err=%b lat=%0d", d, err, lat);
    endtask

    task automatic test_boundaries();
        int lat;
        bit to;
        run_op(24'd3137, 24'd3120, lat, to);
        check_timeout("wrap_3137_3120", to, lat);
        total++;
        if (d !== 24'd2753 || err !== 1'b0) begin
            $display("FAIL wrap_3137_3120 d=%0d err=%b, required d=2753 err=0", d, err);
            bad++;
        end
        $display("op e=3137 totient=3120: d=%0d err=%b lat=%0d", d, err, lat);

        run_op(24'd1, 24'd97, lat, to);
        check_timeout("unit_1_97", to, lat);
        total++;
        if (d !== 24'd1 || err !== 1'b0) begin
            $display("FAIL unit_1_97 d=%0d err=%b, required d=1 err=0", d, err);
            bad++;
        end
        $display("op e=1 totient=97: d=%0d err=%b lat=%0d", d, err, lat);

        run_op(24'd5, 24'd1, lat, to);
        check_timeout("tot1", to, lat);
        total++;
        if (err !== 1'b1 || d !== 24'd0 || lat != 3) begin
            $display("FAIL tot1 err=%b d=%0d lat=%0d, required err=1 d=0 lat=3", err, d, lat);
            bad++;
        end
        $display("op e=5 totient=1: d=%0d err=%b lat=%0d", d, err, lat);

        run_op(24'd0, 24'd3120, lat, to);
        check_timeout("e0", to, lat);
        total++;
        if (err !== 1'b1 || d !== 24'd0 || lat != 3) begin
            $display("FAIL e0 err=%b d=%0d lat=%0d, required err=1 d=0 lat=3", err, d, lat);
            bad++;
        end
        $display("op e=0 totient=3120: d=%0d err=%b lat=%0d", d, err, lat);
    endtask

    task automatic test_start_while_busy();
        bit fin;
        bit quiet;
        @(negedge clk);
        e       = 24'd17;
        totient = 24'd3120;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        e       = 24'd5;
        totient = 24'd26;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        fin = 1'b0;
        for (int i = 0; i < BOUND; i++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) begin
                fin = 1'b1;
                break;
            end
        end
        check_timeout("busy_start", !fin, BOUND);
        total++;
        if (d !== 24'd2753 || err !== 1'b0) begin
            $display("FAIL busy_start_result d=%0d err=%b, required d=2753 err=0", d, err);
            bad++;
        end
        quiet = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (busy !== 1'b0 || done !== 1'b1 || d !== 24'd2753) quiet = 1'b0;
        end
        total++;
        if (!quiet) begin
            $display("FAIL busy_start_no_restart busy=%b done=%b d=%0d, required busy=0 done=1 d=2753", busy, done, d);
            bad++;
        end
        $display("op e=17 totient=3120 with ignored start: d=%0d err=%b", d, err);
    endtask

    task automatic test_reset_mid();
        int lat;
        bit to;
        bit idle_ok;
        @(negedge clk);
        e       = 24'd17;
        totient = 24'd3120;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (8) @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        total++;
        if ({busy, done, err, d} !== {3'b000, {W{1'b0}}}) begin
            $display("FAIL reset_mid busy=%b done=%b err=%b d=%0d, required all 0", busy, done, err, d);
            bad++;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        idle_ok = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #1;
            if (busy !== 1'b0 || done !== 1'b0) idle_ok = 1'b0;
        end
        total++;
        if (!idle_ok) begin
            $display("FAIL reset_mid_aborted busy=%b done=%b, required 0 after abort", busy, done);
            bad++;
        end
        run_op(24'd7, 24'd40, lat, to);
        check_timeout("after_reset_7_40", to, lat);
        total++;
        if (d !== 24'd23 || err !== 1'b0) begin
            $display("FAIL after_reset_7_40 d=%0d err=%b, required d=23 err=0", d, err);
            bad++;
        end
        $display("op e=7 totient=40 after reset: d=%0d err=%b lat=%0d", d, err, lat);
    endtask

`ifdef MODINV_CYCLE_CNT_EN
    task automatic test_cycle_count();
        int lat;
        bit to;
        run_op(24'd3, 24'd20, lat, to);
        check_timeout("cycles_3_20", to, lat);
        // The counter starts at 0 on the accepting edge, so it reads lat-1.
        total++;
        if (int'(cycles) != lat - 1) begin
            $display("FAIL cycles_3_20 cycles=%0d, required %0d", cycles, lat - 1);
            bad++;
        end
        $display("op e=3 totient=20: cycles=%0d lat=%0d", cycles, lat);
    endtask
`endif

    task automatic test_random();
        int lat;
        bit to;
        int bits;
        logic [W-1:0] ev;
        logic [W-1:0] tv;
        longint unsigned prod;
        bit exp_ok;
        for (int n = 0; n < 100; n++) begin
            bits = $urandom_range(2, W);
            tv   = W'($urandom & ((32'd1 << bits) - 1));
            ev   = W'($urandom & ((32'd1 << $urandom_range(1, bits)) - 1));
            if ($urandom_range(0, 9) == 0) ev = tv + W'($urandom_range(0, 5));
            run_op(ev, tv, lat, to);
            check_timeout("random", to, lat);
            exp_ok = invertible_ref(longint'(ev), longint'(tv));
            prod   = longint'(ev) * longint'(d);
            total++;
            if (exp_ok) begin
                if (err !== 1'b0 || d == 0 || d >= tv || (prod % longint'(tv)) != 1) begin
                    $display("FAIL random e=%0d totient=%0d: d=%0d err=%b, required err=0 and e*d mod totient=1",
                             ev, tv, d, err);
                    bad++;
                end
            end else begin
                if (err !== 1'b1 || d !== '0) begin
                    $display("FAIL random e=%0d totient=%0d: d=%0d err=%b, required err=1 d=0", ev, tv, d, err);
                    bad++;
                end
            end
            $display("op e=%0d totient=%0d: d=%0d err=%b lat=%0d", ev, tv, d, err, lat);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_basic();
        test_busy_flag();
        test_small();
        test_boundaries();
        test_start_while_busy();
        test_reset_mid();
`ifdef MODINV_CYCLE_CNT_EN
        test_cycle_count();
`endif
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
